// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants, types and helpers for the push-button counter
package btn_pkg;

    // Counting behaviour at the bounds.
    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    // Action taken on the counter in a given cycle.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2
    } count_op_e;

    // Ceiling log2, never less than 1 so it can size a register directly.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and press-edge pulse generator
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    assign level = stable;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from the accepted one
    // for DEBOUNCE consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered one-cycle pulse on each accepted press; releases are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d   <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            stable_d   <= stable;
            rise_pulse <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/btn_updown_counter.sv
// rtl/btn_updown_counter.sv - two-button debounced up/down counter with wrap or saturate bounds
module btn_updown_counter
    import btn_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int WRAP     = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic [WIDTH-1:0] counter,
    output logic             up_edge,
    output logic             dn_edge,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    // Reject configurations the datapath cannot honour.
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("btn_updown_counter: DEBOUNCE must be >= 1");
    end
    if ((MAX_VAL < 1) || (MAX_VAL > (2**WIDTH - 1))) begin : g_bad_max_val
        $error("btn_updown_counter: MAX_VAL must be in 1 .. 2**WIDTH-1");
    end

    logic      up_level;
    logic      dn_level;
    logic      unused_levels;
    count_op_e op;

    // Accepted levels are only needed for the edge logic inside the debouncers.
    assign unused_levels = up_level ^ dn_level;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_up_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_up),
        .level      (up_level),
        .rise_pulse (up_edge)
    );

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_dn_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_dn),
        .level      (dn_level),
        .rise_pulse (dn_edge)
    );

    // Simultaneous up and down presses cancel out.
    always_comb begin
        op = OP_HOLD;
        if (up_edge && !dn_edge) begin
            op = OP_INC;
        end else if (dn_edge && !up_edge) begin
            op = OP_DEC;
        end
    end

    // Counter register: wraps or saturates at 0 and MAX_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else begin
            case (op)
                OP_INC: begin
                    if (counter == MAX_C) begin
                        if (WRAP == MODE_WRAP) begin
                            counter <= '0;
                        end
                    end else begin
                        counter <= counter + WIDTH'(1);
                    end
                end
                OP_DEC: begin
                    if (counter == '0) begin
                        if (WRAP == MODE_WRAP) begin
                            counter <= MAX_C;
                        end
                    end else begin
                        counter <= counter - WIDTH'(1);
                    end
                end
                default: begin
                    counter <= counter;
                end
            endcase
        end
    end

    assign at_max = (counter == MAX_C);
    assign at_min = (counter == '0);

endmodule

// File: tb/tb_btn_updown_counter.sv
// tb/tb_btn_updown_counter.sv - self-checking bench for btn_updown_counter (wrap and saturate instances)
module tb_btn_updown_counter;

    localparam int W    = 4;
    localparam int DEB  = 4;
    localparam int MAXW = 9;
    localparam int MAXS = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn_up = 1'b0;
    logic         btn_dn = 1'b0;

    logic [W-1:0] cnt_w, cnt_s;
    logic         upe_w, dne_w, amax_w, amin_w;
    logic         upe_s, dne_s, amax_s, amin_s;

    always #10 clk = ~clk;

    btn_updown_counter #(
        .WIDTH(W), .DEBOUNCE(DEB), .MAX_VAL(MAXW), .WRAP(1)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
        .counter(cnt_w), .up_edge(upe_w), .dn_edge(dne_w),
        .at_max(amax_w), .at_min(amin_w)
    );

    btn_updown_counter #(
        .WIDTH(W), .DEBOUNCE(DEB), .MAX_VAL(MAXS), .WRAP(0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
        .counter(cnt_s), .up_edge(upe_s), .dn_edge(dne_s),
        .at_max(amax_s), .at_min(amin_s)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit raw_up_q[$], raw_dn_q[$], obs_up_q[$], obs_dn_q[$];
    bit m_lvl_up, m_lvl_dn, m_pend_up, m_pend_dn, m_pulse_up, m_pulse_dn;
    int m_cw, m_cs;

    typedef struct {
        bit up;
        bit dn;
        bit exp_up_edge;
        int exp_count;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A new level is accepted once the last DEB synchronised samples all differ from it.
    function automatic bit settled(input bit q[$], input bit lvl);
        if (q.size() < DEB) return 1'b0;
        for (int i = 0; i < DEB; i++) begin
            if (q[q.size() - 1 - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit u, input bit d, input bit r);
        bit ou, od;
        if (!r) begin
            raw_up_q.delete(); raw_dn_q.delete(); obs_up_q.delete(); obs_dn_q.delete();
            m_lvl_up = 0; m_lvl_dn = 0; m_pend_up = 0; m_pend_dn = 0;
            m_pulse_up = 0; m_pulse_dn = 0; m_cw = 0; m_cs = 0;
            return;
        end
        if (m_pulse_up && !m_pulse_dn) begin
            m_cw = (m_cw + 1) % (MAXW + 1);
            m_cs = (m_cs < MAXS) ? m_cs + 1 : MAXS;
        end else if (m_pulse_dn && !m_pulse_up) begin
            m_cw = (m_cw + MAXW) % (MAXW + 1);
            m_cs = (m_cs > 0) ? m_cs - 1 : 0;
        end
        m_pulse_up = m_pend_up;
        m_pulse_dn = m_pend_dn;
        // The debouncer sees the raw value from two edges earlier.
        ou = (raw_up_q.size() >= 2) ? raw_up_q[raw_up_q.size() - 2] : 1'b0;
        od = (raw_dn_q.size() >= 2) ? raw_dn_q[raw_dn_q.size() - 2] : 1'b0;
        raw_up_q.push_back(u);
        raw_dn_q.push_back(d);
        obs_up_q.push_back(ou);
        obs_dn_q.push_back(od);
        m_pend_up = 0;
        m_pend_dn = 0;
        if (settled(obs_up_q, m_lvl_up)) begin
            m_lvl_up  = ~m_lvl_up;
            m_pend_up = m_lvl_up;
        end
        if (settled(obs_dn_q, m_lvl_dn)) begin
            m_lvl_dn  = ~m_lvl_dn;
            m_pend_dn = m_lvl_dn;
        end
        if (raw_up_q.size() > 16) void'(raw_up_q.pop_front());
        if (raw_dn_q.size() > 16) void'(raw_dn_q.pop_front());
        if (obs_up_q.size() > 16) void'(obs_up_q.pop_front());
        if (obs_dn_q.size() > 16) void'(obs_dn_q.pop_front());
    endtask

    task automatic compare_all();
        check("w_counter", 32'(cnt_w), 32'(m_cw));
        check("w_up_edge", 32'(upe_w), 32'(m_pulse_up));
        check("w_dn_edge", 32'(dne_w), 32'(m_pulse_dn));
        check("w_at_max", 32'(amax_w), 32'(m_cw == MAXW));
        check("w_at_min", 32'(amin_w), 32'(m_cw == 0));
        check("s_counter", 32'(cnt_s), 32'(m_cs));
        check("s_up_edge", 32'(upe_s), 32'(m_pulse_up));
        check("s_dn_edge", 32'(dne_s), 32'(m_pulse_dn));
        check("s_at_max", 32'(amax_s), 32'(m_cs == MAXS));
        check("s_at_min", 32'(amin_s), 32'(m_cs == 0));
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(input bit u, input bit d, input bit r);
        btn_up = u;
        btn_dn = d;
        rst_n  = r;
        @(posedge clk);
        model_edge(u, d, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input bit u, input bit d);
        for (int i = 0; i < DEB + 4; i++) step(u, d, 1'b1);
        for (int i = 0; i < DEB + 4; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int pulses;
        int up_at, dn_at;
        int rem_u, rem_d;
        bit ru, rd;

        for (int i = 0; i < 18; i++) begin
            tbl[i].up          = (i < 10);
            tbl[i].dn          = 1'b0;
            tbl[i].exp_up_edge = (i == 6);
            tbl[i].exp_count   = (i >= 7) ? 1 : 0;
        end

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        check("reset_counter", 32'(cnt_w), 32'd0);
        check("reset_at_min", 32'(amin_w), 32'd1);
        check("reset_at_max", 32'(amax_s), 32'd0);
        check("reset_up_edge", 32'(upe_w), 32'd0);
        step(1'b0, 1'b0, 1'b1);

        // Clean 200 ns press: pulse seven cycles after the first sample, then count.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].up, tbl[i].dn, 1'b1);
            check("tbl_up_edge", 32'(upe_w), 32'(tbl[i].exp_up_edge));
            check("tbl_counter", 32'(cnt_w), 32'(tbl[i].exp_count));
            check("tbl_counter_sat", 32'(cnt_s), 32'(tbl[i].exp_count));
        end

        // Bouncing press yields exactly one pulse.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(i % 2 == 0, 1'b0, 1'b1);
            pulses += upe_w;
        end
        for (int i = 0; i < 16; i++) begin
            step(i < 8, 1'b0, 1'b1);
            pulses += upe_w;
        end
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_counter", 32'(cnt_w), 32'd2);

        // Short glitch is filtered.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(i < 2, 1'b0, 1'b1);
            pulses += upe_w;
        end
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_counter", 32'(cnt_w), 32'd2);

        // Wrap at MAX_VAL = 9 in both directions.
        do_reset();
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
        check("wrap_at_9", 32'(cnt_w), 32'd9);
        check("wrap_at_max", 32'(amax_w), 32'd1);
        press(1'b1, 1'b0);
        check("wrap_up_to_0", 32'(cnt_w), 32'd0);
        check("wrap_at_min", 32'(amin_w), 32'd1);
        press(1'b0, 1'b1);
        check("wrap_dn_to_9", 32'(cnt_w), 32'd9);
        check("wrap_dn_at_max", 32'(amax_w), 32'd1);

        // Saturation at 15 and 0.
        do_reset();
        for (int i = 0; i < 17; i++) press(1'b1, 1'b0);
        check("sat_top", 32'(cnt_s), 32'd15);
        check("sat_at_max", 32'(amax_s), 32'd1);
        for (int i = 0; i < 16; i++) press(1'b0, 1'b1);
        check("sat_bottom", 32'(cnt_s), 32'd0);
        check("sat_at_min", 32'(amin_s), 32'd1);

        // Simultaneous presses: both pulses together, no count change.
        do_reset();
        up_at = -1;
        dn_at = -1;
        for (int i = 0; i < 2 * (DEB + 4); i++) begin
            step(i < DEB + 4, i < DEB + 4, 1'b1);
            if (upe_w && up_at < 0) up_at = i;
            if (dne_w && dn_at < 0) dn_at = i;
        end
        check("simul_up_seen", 32'(up_at >= 0), 32'd1);
        check("simul_same_cycle", 32'(up_at), 32'(dn_at));
        check("simul_counter", 32'(cnt_w), 32'd0);

        // Reset while debouncing a held button; the held button counts once after release.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0);
            pulses += upe_w;
        end
        check("rst_no_pulse", 32'(pulses), 32'd0);
        check("rst_counter", 32'(cnt_w), 32'd0);
        up_at = -1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b1);
            pulses += upe_w;
            if (upe_w && up_at < 0) up_at = i;
        end
        check("rst_pulse_latency", 32'(up_at), 32'(DEB + 2));
        check("rst_pulse_count", 32'(pulses), 32'd1);
        check("rst_counter_after", 32'(cnt_w), 32'd1);
        for (int i = 0; i < DEB + 4; i++) step(1'b0, 1'b0, 1'b1);

        // Random button activity against the model, with occasional resets.
        rem_u = 0;
        rem_d = 0;
        ru = 0;
        rd = 0;
        for (int i = 0; i < 1500; i++) begin
            if (rem_u == 0) begin
                ru = $urandom_range(0, 1);
                rem_u = $urandom_range(1, 12);
            end
            if (rem_d == 0) begin
                rd = $urandom_range(0, 1);
                rem_d = $urandom_range(1, 12);
            end
            rem_u--;
            rem_d--;
            step(ru, rd, $urandom_range(0, 299) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
